dpd_delay_sched: RTL and testbench

DPD_DELAY_SCHED -- requirements
Module: dpd_delay_sched

---
 rtl/dpd_actuator_pkg.sv | 23 ++
 rtl/dpd_delay_ram.sv | 36 +++
 rtl/dpd_delay_sched.sv | 163 ++++++++++++++++
 tb/tb_dpd_delay_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_actuator_pkg.sv
// Shared definitions for the DPD delay scheduler.
//   sched_state_e : scheduler states (IDLE, FILL, RUN)
//   calc_aw()     : address width AW for a given buffer depth
//   clamp_delay() : limits a requested delay to the buffer depth
package dpd_actuator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_e;

  // Delay fields are AW+1 bits so that a delay equal to the full depth fits.
  function automatic int calc_aw(input int max_taps);
    return $clog2(max_taps);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_taps);
    return (req > max_taps) ? max_taps : req;
  endfunction

endpackage

// File: rtl/dpd_delay_ram.sv
// Circular sample buffer, DWIDTH x MAX_TAPS, read-before-write.
//   clk_i   : clock, rising edge
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : sample to store
//   raddr_i : read index (combinational read of the pre-write contents)
//   rdata_o : sample at raddr_i
// Contents are intentionally not reset; the scheduler masks stale entries.
module dpd_delay_ram
  import dpd_actuator_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int MAX_TAPS = 16,
  localparam int AW      = calc_aw(MAX_TAPS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [MAX_TAPS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read returns the old value when raddr_i == waddr_i,
  // which is what a delay of exactly MAX_TAPS relies on.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dpd_delay_sched.sv
// Programmable sample delay line with fill/lock scheduling.
//   clk_i, rst_i      : clock (rising edge), async active-high reset
//   en_i              : block enable, low returns to IDLE
//   din_i/din_valid_i : input samples
//   dout_o/dout_valid_o : delayed samples (registered, held when not valid)
//   cfg_delay_i, cfg_valid_i, cfg_ready_o : delay reconfiguration handshake
//   cur_delay_o       : delay in force
//   locked_o          : high while in RUN
//   cfg_err_o         : one-cycle pulse when a request was clamped
module dpd_delay_sched
  import dpd_actuator_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int MAX_TAPS  = 16,
  parameter int DEF_DELAY = 2,
  localparam int AW       = calc_aw(MAX_TAPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DWIDTH-1:0] din_i,
  input  logic              din_valid_i,
  output logic [DWIDTH-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic [AW:0]       cfg_delay_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic [AW:0]       cur_delay_o,
  output logic              locked_o,
  output logic              cfg_err_o
);

  sched_state_e      state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       fill_cnt_q, fill_cnt_d;
  logic [AW:0]       cur_delay_q, cur_delay_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              cfg_err_q, cfg_err_d;

  logic              ram_we;
  logic [AW-1:0]     ram_raddr;
  logic [DWIDTH-1:0] ram_rdata;
  logic [DWIDTH-1:0] out_sample;
  logic              cfg_accept;
  logic [AW:0]       clamped_delay;

  assign cfg_ready_o   = (state_q != ST_FILL);
  assign cfg_accept    = cfg_valid_i & cfg_ready_o;
  assign clamped_delay = (AW+1)'(clamp_delay(32'(cfg_delay_i), MAX_TAPS));

  // Modulo arithmetic on AW bits: a delay of MAX_TAPS truncates to 0 and
  // so addresses the slot about to be overwritten.
  assign ram_raddr  = wr_ptr_q - cur_delay_q[AW-1:0];
  assign out_sample = (cur_delay_q == '0) ? din_i : ram_rdata;

  dpd_delay_ram #(
    .DWIDTH   (DWIDTH),
    .MAX_TAPS (MAX_TAPS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (din_i),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      cur_delay_q  <= (AW+1)'(DEF_DELAY);
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      cur_delay_q  <= cur_delay_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    cur_delay_d  = cur_delay_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    cfg_err_d    = 1'b0;
    ram_we       = 1'b0;

    if (cfg_accept) begin
      cur_delay_d = clamped_delay;
      cfg_err_d   = (clamped_delay != cfg_delay_i);
    end

    unique case (state_q)
      ST_IDLE: begin
        wr_ptr_d   = '0;
        fill_cnt_d = '0;
        if (en_i) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (din_valid_i) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // The strobe that finds fill_cnt already equal to the delay is the
          // first one whose look-back sample was written after the restart.
          if (fill_cnt_q == cur_delay_q) begin
            state_d      = ST_RUN;
            dout_valid_d = 1'b1;
            dout_d       = out_sample;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (din_valid_i) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          // A sample arriving with a reconfiguration is stored but not output;
          // counting under the new delay begins with the following strobe.
          if (!cfg_accept) begin
            dout_valid_d = 1'b1;
            dout_d       = out_sample;
          end
        end
        if (cfg_accept) begin
          fill_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!en_i) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      fill_cnt_d   = '0;
      dout_valid_d = 1'b0;
      ram_we       = 1'b0;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign cur_delay_o  = cur_delay_q;
  assign locked_o     = (state_q == ST_RUN);
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_dpd_delay_sched.sv
// Self-checking bench for dpd_delay_sched: a sample-history model predicts
// every registered output each cycle, and directed checks pin key values.
module tb_dpd_delay_sched;

  localparam int DW   = 16;
  localparam int TAPS = 16;
  localparam int DEFD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dinValid = 1'b0;
  logic [4:0]    cfgDelay = '0;
  logic          cfgValid = 1'b0;
  logic [DW-1:0] dout;
  logic          doutValid;
  logic          cfgReady;
  logic [4:0]    curDelay;
  logic          locked;
  logic          cfgErr;

  int testsRun = 0;
  int testsFailed = 0;

  dpd_delay_sched #(
    .DWIDTH    (DW),
    .MAX_TAPS  (TAPS),
    .DEF_DELAY (DEFD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .din_i        (din),
    .din_valid_i  (dinValid),
    .dout_o       (dout),
    .dout_valid_o (doutValid),
    .cfg_delay_i  (cfgDelay),
    .cfg_valid_i  (cfgValid),
    .cfg_ready_o  (cfgReady),
    .cur_delay_o  (curDelay),
    .locked_o     (locked),
    .cfg_err_o    (cfgErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the clock edge take them, and return
  // shortly after the edge so registered outputs can be inspected.
  task automatic applyStimulus(input logic e, input logic v, input int d,
                               input logic cv, input int cd);
    en       = e;
    dinValid = v;
    din      = DW'(d);
    cfgValid = cv;
    cfgDelay = 5'(cd);
    @(posedge clk);
    #1;
  endtask

  // Model: the block is either off, masking strobes after a (re)start, or
  // locked; a locked strobe outputs the sample accepted 'delay' strobes ago.
  int  modelHist[$];
  bit  mOn, mLocked, mAcc;
  int  mSkip, mDelay, mReq, mNewDelay, mIdx;
  int  expDout;
  bit  expDv, expErr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mOn     = 0;
      mLocked = 0;
      mSkip   = 0;
      mDelay  = DEFD;
      expDout = 0;
      expDv   = 0;
      expErr  = 0;
      modelHist.delete();
    end else begin
      mAcc      = cfgValid && (!mOn || mLocked);
      mReq      = int'(cfgDelay);
      mNewDelay = (mReq > TAPS) ? TAPS : mReq;
      expErr    = mAcc && (mReq > TAPS);
      expDv     = 0;
      if (!en) begin
        if (mAcc) mDelay = mNewDelay;
        mOn     = 0;
        mLocked = 0;
        modelHist.delete();
      end else if (!mOn) begin
        if (mAcc) mDelay = mNewDelay;
        mOn     = 1;
        mLocked = 0;
        mSkip   = mDelay;
      end else begin
        if (dinValid) begin
          if (!mAcc) begin
            if (mSkip > 0) begin
              mSkip--;
            end else begin
              if (mDelay == 0) begin
                expDout = int'(din);
              end else begin
                mIdx = modelHist.size() - mDelay;
                expDout = (mIdx >= 0) ? modelHist[mIdx] : -1;
              end
              expDv   = 1;
              mLocked = 1;
            end
          end
          modelHist.push_back(int'(din));
          if (modelHist.size() > 40) void'(modelHist.pop_front());
        end
        if (mAcc) begin
          mDelay  = mNewDelay;
          mSkip   = mNewDelay;
          mLocked = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("cmp_dout_valid", int'(doutValid), int'(expDv));
    checkOutput("cmp_dout", int'(dout), expDout);
    checkOutput("cmp_locked", int'(locked), int'(mOn && mLocked));
    checkOutput("cmp_cfg_ready", int'(cfgReady), int'(!mOn || mLocked));
    checkOutput("cmp_cur_delay", int'(curDelay), mDelay);
    checkOutput("cmp_cfg_err", int'(cfgErr), int'(expErr));
  end

  initial begin
    int s;
    int first;
    int nStrobe;
    s = 1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_dout", int'(dout), 0);
    checkOutput("reset_dout_valid", int'(doutValid), 0);
    checkOutput("reset_cur_delay", int'(curDelay), 2);
    checkOutput("reset_locked", int'(locked), 0);
    checkOutput("reset_cfg_ready", int'(cfgReady), 1);
    checkOutput("reset_cfg_err", int'(cfgErr), 0);

    // Default delay 2 with a continuous ramp.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fill_cfg_ready", int'(cfgReady), 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, s, 0, 0);
      if (s == 3) begin
        checkOutput("first_valid", int'(doutValid), 1);
        checkOutput("first_dout", int'(dout), 1);
        checkOutput("first_locked", int'(locked), 1);
      end
      s++;
    end
    checkOutput("ramp_dout", int'(dout), 8);

    // Reconfigure to 5 together with a sample (s = 11).
    applyStimulus(1, 1, s, 1, 5);
    s++;
    checkOutput("reconf_dout_valid", int'(doutValid), 0);
    checkOutput("reconf_cfg_ready", int'(cfgReady), 0);
    checkOutput("reconf_cur_delay", int'(curDelay), 5);
    checkOutput("reconf_dout_hold", int'(dout), 8);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1, 1, s, 0, 0);
      if (k < 6) begin
        checkOutput("d5_masked", int'(doutValid), 0);
      end else begin
        checkOutput("d5_valid", int'(doutValid), 1);
        checkOutput("d5_dout", int'(dout), 12);
        checkOutput("d5_locked", int'(locked), 1);
      end
      s++;
    end

    // Delay 0: bypass through one register.
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("d0_cur_delay", int'(curDelay), 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, s, 0, 0);
      checkOutput("d0_valid", int'(doutValid), 1);
      checkOutput("d0_dout", int'(dout), s);
      s++;
    end

    // Delay 16: full-depth look-back.
    applyStimulus(1, 0, 0, 1, 16);
    checkOutput("d16_cur_delay", int'(curDelay), 16);
    first = s;
    for (int k = 0; k <= 17; k++) begin
      applyStimulus(1, 1, s, 0, 0);
      if (k < 16) begin
        checkOutput("d16_masked", int'(doutValid), 0);
      end else begin
        checkOutput("d16_valid", int'(doutValid), 1);
        checkOutput("d16_dout", int'(dout), first + k - 16);
      end
      s++;
    end

    // Over-range request is clamped and flagged for one cycle.
    applyStimulus(1, 0, 0, 1, 20);
    checkOutput("clamp_cur_delay", int'(curDelay), 16);
    checkOutput("clamp_err", int'(cfgErr), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clamp_err_drop", int'(cfgErr), 0);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1, 1, s, 0, 0);
      s++;
    end
    checkOutput("clamp_relock", int'(locked), 1);

    // Delay 3 with din_valid alternating.
    applyStimulus(1, 0, 0, 1, 3);
    nStrobe = 0;
    first = s;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1, 1, s, 0, 0);
        nStrobe++;
        if (nStrobe == 4) begin
          checkOutput("d3_valid", int'(doutValid), 1);
          checkOutput("d3_dout", int'(dout), first);
        end
        s++;
      end else begin
        applyStimulus(1, 0, 0, 0, 0);
        if (nStrobe == 4) begin
          checkOutput("d3_gap_valid", int'(doutValid), 0);
          checkOutput("d3_gap_hold", int'(dout), first);
        end
      end
    end

    // Asynchronous reset in RUN.
    applyStimulus(1, 1, s, 0, 0);
    s++;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_dout_valid", int'(doutValid), 0);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_cur_delay", int'(curDelay), 2);
    #3 rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    first = s;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, s, 0, 0);
      s++;
    end
    checkOutput("rst_refill_valid", int'(doutValid), 1);
    checkOutput("rst_refill_dout", int'(dout), first);

    // Enable dropped during FILL, then reconfigured while idle.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, s, 0, 0);
    s++;
    applyStimulus(0, 1, s, 0, 0);
    s++;
    checkOutput("en_drop_valid", int'(doutValid), 0);
    checkOutput("en_drop_locked", int'(locked), 0);
    checkOutput("en_drop_cfg_ready", int'(cfgReady), 1);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("idle_cfg_delay", int'(curDelay), 3);
    checkOutput("idle_cfg_locked", int'(locked), 0);
    checkOutput("idle_cfg_ready", int'(cfgReady), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("resume_cfg_ready", int'(cfgReady), 0);
    first = s;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1, s, 0, 0);
      if (k < 3) checkOutput("resume_masked", int'(doutValid), 0);
      s++;
    end
    checkOutput("resume_valid", int'(doutValid), 1);
    checkOutput("resume_dout", int'(dout), first);

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
